alu_arbiter: RTL and testbench

Round-robin scheduler that shares the single 8-bit ALU peripheral on the 23-bit peripheral bus `pData` between `N_REQ` requesters. Each granted request is expanded into the fixed bus sequence write-A, write-B, read-result. The captured result is returned to the requester with a one-cycle acknowledge. The block is the only bus master for peripheral addresses 20–29 and sits between the task units and the ALU peripheral.

---
 rtl/alu_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin scheduler sharing one ALU peripheral on pData among N_REQ requesters.
// Latency: ack 3 cycles after the IDLE grant edge for valid ops (WR_A, WR_B, RD, DONE); 1 cycle for invalid ops.
// Backpressure: requesters hold req until their ack pulse; others wait in round-robin order from ptr.
module alu_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic                 fastClk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [4*N_REQ-1:0]   op,
    input  logic [8*N_REQ-1:0]   a_in,
    input  logic [8*N_REQ-1:0]   b_in,
    output logic [N_REQ-1:0]     ack,
    output logic                 err,
    output logic [7:0]           result,
    output logic                 busy,
    inout  wire  [22:0]          pData
);

    localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDXW:0]   NREQ_W   = (IDXW+1)'(N_REQ);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_REQ - 1);
    localparam logic [5:0]      ADDR_A   = 6'd20;
    localparam logic [5:0]      ADDR_B   = 6'd21;
    localparam logic [3:0]      OP_MAX   = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR_A = 3'd1,
        S_WR_B = 3'd2,
        S_RD   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [IDXW-1:0]   ptr_q, ptr_d;
    logic [3:0]        op_q, op_d;
    logic [7:0]        a_q, a_d;
    logic [7:0]        b_q, b_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic              err_q, err_d;
    logic [7:0]        result_q, result_d;
    logic              busy_q, busy_d;
    logic              stb_q, stb_d;
    logic [5:0]        addr_q, addr_d;
    logic [7:0]        wdat_q, wdat_d;

    logic [3:0]        op_arr [N_REQ];
    logic [7:0]        a_arr  [N_REQ];
    logic [7:0]        b_arr  [N_REQ];

    logic              grant_vld;
    logic [IDXW-1:0]   grant_idx;
    logic [IDXW:0]     scan_idx;

    // Unpack the flat per-requester operand buses into indexable arrays.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign op_arr[gi] = op[4*gi +: 4];
        assign a_arr[gi]  = a_in[8*gi +: 8];
        assign b_arr[gi]  = b_in[8*gi +: 8];
    end

    // Round-robin pick: first requester at or after ptr, scanning upward with wrap.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = {1'b0, ptr_q} + (IDXW+1)'(k);
            if (scan_idx >= NREQ_W) begin
                scan_idx = scan_idx - NREQ_W;
            end
            if (!grant_vld && req[scan_idx[IDXW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx[IDXW-1:0];
            end
        end
    end

    // Next-state and registered-output logic; bus fields follow the state being entered.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        ack_d    = '0;
        err_d    = 1'b0;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    idx_d = grant_idx;
                    op_d  = op_arr[grant_idx];
                    a_d   = a_arr[grant_idx];
                    b_d   = b_arr[grant_idx];
                    if (op_arr[grant_idx] > OP_MAX) begin
                        // Unsupported op: answer immediately, never touch the bus.
                        state_d          = S_DONE;
                        err_d            = 1'b1;
                        result_d         = 8'h00;
                        ack_d[grant_idx] = 1'b1;
                    end else begin
                        state_d = S_WR_A;
                    end
                end
            end
            S_WR_A: state_d = S_WR_B;
            S_WR_B: state_d = S_RD;
            S_RD: begin
                result_d     = pData[15:8];
                ack_d[idx_q] = 1'b1;
                state_d      = S_DONE;
            end
            S_DONE: begin
                ptr_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        stb_d  = 1'b0;
        addr_d = 6'd0;
        wdat_d = 8'h00;
        case (state_d)
            S_WR_A: begin
                stb_d  = 1'b1;
                addr_d = ADDR_A;
                wdat_d = a_d;
            end
            S_WR_B: begin
                stb_d  = 1'b1;
                addr_d = ADDR_B;
                wdat_d = b_d;
            end
            S_RD: begin
                addr_d = ADDR_A + {2'b00, op_d};
            end
            default: ;
        endcase
    end

    // State and output registers with synchronous reset to idle.
    always_ff @(posedge fastClk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            ptr_q    <= '0;
            op_q     <= 4'd0;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            ack_q    <= '0;
            err_q    <= 1'b0;
            result_q <= 8'h00;
            busy_q   <= 1'b0;
            stb_q    <= 1'b0;
            addr_q   <= 6'd0;
            wdat_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            stb_q    <= stb_d;
            addr_q   <= addr_d;
            wdat_q   <= wdat_d;
        end
    end

    assign ack    = ack_q;
    assign err    = err_q;
    assign result = result_q;
    assign busy   = busy_q;

    // Read-data byte [15:8] is left undriven; the peripheral owns it.
    assign pData[22]    = stb_q;
    assign pData[21:16] = addr_q;
    assign pData[7:0]   = wdat_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    localparam int N = 4;

    logic             fastClk;
    logic             rst;
    logic [N-1:0]     req;
    logic [4*N-1:0]   op;
    logic [8*N-1:0]   a_in;
    logic [8*N-1:0]   b_in;
    logic [N-1:0]     ack;
    logic             err;
    logic [7:0]       result;
    logic             busy;
    wire  [22:0]      pData;

    logic [7:0]       prd;
    assign pData[15:8] = prd;

    int total = 0;
    int bad   = 0;

    alu_arbiter #(.N_REQ(N)) dut (
        .fastClk (fastClk),
        .rst     (rst),
        .req     (req),
        .op      (op),
        .a_in    (a_in),
        .b_in    (b_in),
        .ack     (ack),
        .err     (err),
        .result  (result),
        .busy    (busy),
        .pData   (pData)
    );

    initial begin
        fastClk = 1'b0;
        forever #5 fastClk = ~fastClk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] alu_f(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
        logic [15:0] p;
        p = 16'(x) * 16'(y);
        case (o)
            4'd0: return x + y;
            4'd1: return x - y;
            4'd2: return p[7:0];
            4'd3: return x | y;
            4'd4: return (x != 0 && y != 0) ? 8'h01 : 8'h00;
            4'd5: return ~x;
            4'd6: return x << y[2:0];
            4'd7: return x >> y[2:0];
            4'd8: return (x < y) ? 8'hC0 : 8'h00;
            4'd9: return (x == y) ? 8'hC0 : 8'h00;
            default: return 8'hEE;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Inputs as the DUT saw them at the last rising edge.
    logic           s_rst;
    logic [N-1:0]   s_req;
    logic [4*N-1:0] s_op;
    logic [8*N-1:0] s_a;
    logic [8*N-1:0] s_b;
    always @(posedge fastClk) begin
        s_rst <= rst;
        s_req <= req;
        s_op  <= op;
        s_a   <= a_in;
        s_b   <= b_in;
    end

    // Peripheral model plus transaction-level reference model and per-cycle compare.
    logic [7:0] pa = 8'h00;
    logic [7:0] pb = 8'h00;
    bit         m_act = 0;
    bit         m_inv = 0;
    int         m_k = 0;
    int         m_last = 0;
    int         m_idx = 0;
    int         m_ptr = 0;
    logic [3:0] m_op = 0;
    logic [7:0] m_a = 0;
    logic [7:0] m_b = 0;
    logic [7:0] m_res = 0;
    initial begin
        logic [31:0] e_ack;
        logic        e_err;
        logic        e_stb;
        logic [5:0]  e_addr;
        logic [7:0]  e_wd;
        int          c;
        prd = 8'hEE;
        @(posedge fastClk);
        forever begin
            @(negedge fastClk);
            if (pData[22] === 1'b1 && pData[21:16] == 6'd20) pa = pData[7:0];
            if (pData[22] === 1'b1 && pData[21:16] == 6'd21) pb = pData[7:0];
            if (pData[22] === 1'b0 && pData[21:16] >= 6'd20 && pData[21:16] <= 6'd29)
                prd = alu_f(4'(pData[21:16] - 6'd20), pa, pb);
            else
                prd = 8'hEE;

            if (s_rst) begin
                m_act = 0; m_ptr = 0; m_res = 8'h00; m_k = 0;
            end else if (m_act) begin
                m_k++;
                if (m_k > m_last) begin
                    m_act = 0;
                    m_ptr = (m_idx + 1) % N;
                end
            end else if (s_req != 0) begin
                for (int j = 0; j < N; j++) begin
                    c = (m_ptr + j) % N;
                    if (s_req[c]) begin
                        m_idx = c;
                        break;
                    end
                end
                m_op   = s_op[4*m_idx +: 4];
                m_a    = s_a[8*m_idx +: 8];
                m_b    = s_b[8*m_idx +: 8];
                m_inv  = (m_op > 4'd9);
                m_last = m_inv ? 0 : 3;
                m_act  = 1;
                m_k    = 0;
            end

            e_ack = 0; e_err = 0; e_stb = 0; e_addr = 0; e_wd = 0;
            if (m_act && m_k == m_last) begin
                e_ack = 32'(1) << m_idx;
                e_err = m_inv;
                m_res = m_inv ? 8'h00 : alu_f(m_op, m_a, m_b);
            end
            if (m_act && !m_inv) begin
                if (m_k == 0) begin e_stb = 1; e_addr = 6'd20; e_wd = m_a; end
                if (m_k == 1) begin e_stb = 1; e_addr = 6'd21; e_wd = m_b; end
                if (m_k == 2) begin e_stb = 0; e_addr = 6'd20 + 6'(m_op); end
            end
            chk("ack", 32'(ack), e_ack);
            chk("err", 32'(err), 32'(e_err));
            chk("result", 32'(result), 32'(m_res));
            chk("busy", 32'(busy), 32'(m_act));
            chk("bus_stb", 32'(pData[22]), 32'(e_stb));
            chk("bus_addr", 32'(pData[21:16]), 32'(e_addr));
            chk("bus_wdat", 32'(pData[7:0]), 32'(e_wd));
        end
    end

    task automatic wait_ack(input int idx, output int lat);
        lat = 0;
        for (int cy = 1; cy <= 20; cy++) begin
            @(posedge fastClk); #1;
            if (ack[idx]) begin
                lat = cy;
                break;
            end
        end
        if (lat == 0) begin
            total++; bad++;
            $display("FAIL ack_timeout req=%0d actual=none required=ack", idx);
        end
    endtask

    task automatic run_one(input int idx, input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                           input logic [7:0] exp_res, input logic exp_err, input int exp_lat);
        int lat;
        @(posedge fastClk); #1;
        op[4*idx +: 4]   = o;
        a_in[8*idx +: 8] = x;
        b_in[8*idx +: 8] = y;
        req[idx]         = 1'b1;
        wait_ack(idx, lat);
        req[idx] = 1'b0;
        chk("lit_latency", 32'(lat), 32'(exp_lat));
        chk("lit_result", 32'(result), 32'(exp_res));
        chk("lit_err", 32'(err), 32'(exp_err));
    endtask

    task automatic pulse_rst();
        @(posedge fastClk); #1;
        rst = 1'b1;
        @(posedge fastClk); #1;
        rst = 1'b0;
    endtask

    initial begin
        int order [5];
        int when  [5];
        int cnt;
        int cyc;
        rst = 1'b1; req = '0; op = '0; a_in = '0; b_in = '0;
        repeat (3) @(posedge fastClk);
        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_result", 32'(result), 32'(0));
        chk("rst_bus", 32'({pData[22:16], pData[7:0]}), 32'(0));
        rst = 1'b0;

        run_one(0, 4'd0, 8'h12, 8'h34, 8'h46, 1'b0, 4);
        run_one(2, 4'd8, 8'h05, 8'h09, 8'hC0, 1'b0, 4);
        run_one(2, 4'd9, 8'h7F, 8'h7F, 8'hC0, 1'b0, 4);
        run_one(2, 4'd9, 8'h7F, 8'h80, 8'h00, 1'b0, 4);
        run_one(3, 4'd2, 8'h10, 8'h20, 8'h00, 1'b0, 4);
        run_one(3, 4'd2, 8'h0F, 8'h11, 8'hFF, 1'b0, 4);
        run_one(1, 4'd12, 8'h55, 8'h66, 8'h00, 1'b1, 1);

        // Reset while the B operand is on the bus.
        @(posedge fastClk); #1;
        op[7:4] = 4'd0; a_in[15:8] = 8'h03; b_in[15:8] = 8'h04; req[1] = 1'b1;
        @(posedge fastClk); #1;
        @(posedge fastClk); #1;
        chk("wrb_addr", 32'(pData[21:16]), 32'd21);
        rst = 1'b1; req[1] = 1'b0;
        @(posedge fastClk); #1;
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_ack", 32'(ack), 32'(0));
        chk("abort_bus", 32'({pData[22:16], pData[7:0]}), 32'(0));
        repeat (4) @(posedge fastClk);
        run_one(1, 4'd0, 8'h03, 8'h04, 8'h07, 1'b0, 4);

        // Contention with all requesters held.
        pulse_rst();
        for (int i = 0; i < N; i++) begin
            op[4*i +: 4]   = 4'd0;
            a_in[8*i +: 8] = 8'(8'h10 * (i + 1));
            b_in[8*i +: 8] = 8'(i + 1);
        end
        req = '1;
        cnt = 0;
        for (int cy = 1; cy <= 40 && cnt < 5; cy++) begin
            @(posedge fastClk); #1;
            for (int i = 0; i < N; i++) begin
                if (ack[i]) begin
                    order[cnt] = i;
                    when[cnt]  = cy;
                    chk("cont_result", 32'(result), 32'(8'h11 * (i + 1)));
                    cnt++;
                end
            end
        end
        req = '0;
        chk("cont_count", 32'(cnt), 32'd5);
        for (int k = 0; k < 5 && k < cnt; k++) begin
            chk("cont_order", 32'(order[k]), 32'(k % N));
            if (k > 0) chk("cont_spacing", 32'(when[k] - when[k-1]), 32'd5);
        end

        // Randomized traffic checked by the reference model.
        repeat (6) @(posedge fastClk);
        for (cyc = 0; cyc < 3000; cyc++) begin
            @(posedge fastClk); #1;
            rst = ($urandom_range(499) == 0);
            for (int i = 0; i < N; i++) begin
                if (ack[i]) req[i] = 1'b0;
                if (!req[i] && $urandom_range(3) == 0) begin
                    op[4*i +: 4]   = ($urandom_range(5) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(9));
                    a_in[8*i +: 8] = 8'($urandom);
                    b_in[8*i +: 8] = 8'($urandom);
                    req[i]         = 1'b1;
                end
            end
        end
        @(posedge fastClk); #1;
        rst = 1'b0; req = '0;
        repeat (10) @(posedge fastClk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
